tile_map_ram: RTL

TILE_MAP_RAM -- requirements
Module: tile_map_ram

---
 rtl/map_pkg.sv | 33 +++
 rtl/map_layout_rom.sv | 29 ++
 rtl/tile_map_ram.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/map_pkg.sv
// Shared tile codes, tile colours and controller state type for the tile map.
package map_pkg;

  typedef enum logic [1:0] {
    TILE_EMPTY = 2'd0,
    TILE_WALL  = 2'd1,
    TILE_COIN  = 2'd2,
    TILE_OOB   = 2'd3
  } tile_e;

  localparam logic [11:0] RGB_EMPTY = 12'h222;
  localparam logic [11:0] RGB_WALL  = 12'hF00;
  localparam logic [11:0] RGB_COIN  = 12'hFF0;
  localparam logic [11:0] RGB_OOB   = 12'hFFF;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_READY,
    ST_CLEARING
  } state_e;

  function automatic logic [11:0] tile_rgb(input logic [1:0] t);
    logic [11:0] rgb;
    case (t)
      TILE_EMPTY: rgb = RGB_EMPTY;
      TILE_WALL:  rgb = RGB_WALL;
      TILE_COIN:  rgb = RGB_COIN;
      default:    rgb = RGB_OOB;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/map_layout_rom.sv
// Level layout: flat address x*DEPTH+y in, tile code out (combinational).
// Coins sit every 13 rows (y mod 13 == 1); walls on the (x+y) mod 7 == 3 diagonals.
module map_layout_rom
  import map_pkg::*;
#(
  parameter  int unsigned LANES = 5,
  parameter  int unsigned DEPTH = 100,
  localparam int unsigned AW    = $clog2(LANES * DEPTH)
) (
  input  logic [AW-1:0] addr,
  output logic [1:0]    tile
);

  int unsigned x;
  int unsigned y;

  // Split the flat address and apply the level pattern.
  always_comb begin
    x = 32'(addr) / DEPTH;
    y = 32'(addr) % DEPTH;
    if (y % 13 == 1)
      tile = TILE_COIN;
    else if ((x + y) % 7 == 3)
      tile = TILE_WALL;
    else
      tile = TILE_EMPTY;
  end

endmodule

// File: rtl/tile_map_ram.sv
// Tile map store: copies the layout ROM into RAM, then serves reads and coin clears.
module tile_map_ram
  import map_pkg::*;
#(
  parameter  int unsigned LANES   = 5,
  parameter  int unsigned DEPTH   = 100,
  parameter  int unsigned MAP_LEN = 87,
  localparam int unsigned XW      = $clog2(LANES),
  localparam int unsigned YW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          reload,
  output logic          ready,
  input  logic          rd_valid,
  input  logic [XW-1:0] rd_x,
  input  logic [YW-1:0] rd_y,
  output logic          rsp_valid,
  output logic [1:0]    rsp_state,
  output logic [11:0]   rsp_rgb,
  input  logic          clr_valid,
  input  logic [XW-1:0] clr_x,
  input  logic [YW-1:0] clr_y,
  output logic [10:0]   len
);

  localparam int unsigned CELLS = LANES * DEPTH;
  localparam int unsigned AW    = $clog2(CELLS);

  state_e        state_q, state_d;
  logic [AW-1:0] load_addr_q, load_addr_d;
  logic [YW-1:0] load_y_q, load_y_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          ready_q, ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [1:0]    rsp_state_q, rsp_state_d;
  logic [11:0]   rsp_rgb_q, rsp_rgb_d;

  logic [1:0]    mem_q [CELLS];
  logic          we;
  logic [AW-1:0] waddr;
  logic [1:0]    wdata;

  logic [1:0]    rom_tile;
  logic          rd_in, clr_in;
  logic [AW-1:0] rd_addr, clr_addr;

  map_layout_rom #(
    .LANES(LANES),
    .DEPTH(DEPTH)
  ) u_rom (
    .addr(load_addr_q),
    .tile(rom_tile)
  );

  // Request decode: range checks and flat RAM addresses.
  always_comb begin
    rd_in    = (32'(rd_x) < LANES) && (32'(rd_y) < DEPTH);
    clr_in   = (32'(clr_x) < LANES) && (32'(clr_y) < DEPTH);
    rd_addr  = AW'(32'(rd_x) * DEPTH + 32'(rd_y));
    clr_addr = AW'(32'(clr_x) * DEPTH + 32'(clr_y));
  end

  // Next-state, RAM write port and response computation.
  // The response reads mem_q before the clear write lands, so a same-cycle
  // read of a cleared coin returns COIN.
  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    load_y_d    = load_y_q;
    clr_addr_d  = clr_addr_q;
    rsp_valid_d = 1'b0;
    rsp_state_d = rsp_state_q;
    rsp_rgb_d   = rsp_rgb_q;
    we          = 1'b0;
    waddr       = load_addr_q;
    wdata       = TILE_EMPTY;

    case (state_q)
      ST_LOAD: begin
        we    = 1'b1;
        waddr = load_addr_q;
        wdata = (32'(load_y_q) >= MAP_LEN) ? TILE_EMPTY : rom_tile;
        if (load_addr_q == AW'(CELLS - 1)) begin
          state_d = ST_READY;
        end else begin
          load_addr_d = load_addr_q + 1'b1;
          load_y_d    = (load_y_q == YW'(DEPTH - 1)) ? '0 : load_y_q + 1'b1;
        end
      end
      ST_READY: begin
        if (rd_valid) begin
          rsp_valid_d = 1'b1;
          rsp_state_d = rd_in ? mem_q[rd_addr] : TILE_OOB;
          rsp_rgb_d   = tile_rgb(rsp_state_d);
        end
        if (clr_valid && clr_in && (mem_q[clr_addr] == TILE_COIN)) begin
          clr_addr_d = clr_addr;
          state_d    = ST_CLEARING;
        end
      end
      ST_CLEARING: begin
        we      = 1'b1;
        waddr   = clr_addr_q;
        wdata   = TILE_EMPTY;
        state_d = ST_READY;
      end
      default: state_d = ST_LOAD;
    endcase

    if (reload) begin
      state_d     = ST_LOAD;
      load_addr_d = '0;
      load_y_d    = '0;
      rsp_valid_d = 1'b0;
    end

    if (rst) we = 1'b0;

    ready_d = (state_d == ST_READY);
  end

  // Controller and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      load_addr_q <= '0;
      load_y_q    <= '0;
      clr_addr_q  <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_state_q <= '0;
      rsp_rgb_q   <= '0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      load_y_q    <= load_y_d;
      clr_addr_q  <= clr_addr_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_state_q <= rsp_state_d;
      rsp_rgb_q   <= rsp_rgb_d;
    end
  end

  // Tile RAM write port.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign ready     = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_state = rsp_state_q;
  assign rsp_rgb   = rsp_rgb_q;
  assign len       = 11'(MAP_LEN);

endmodule
